// File: rtl/ps2_pkg.sv
// PS/2 keyboard front end: shared enums, scan/HID constants, set-2 to HID lookup.
package ps2_pkg;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_t;

    typedef enum logic [1:0] {
        PFX_NONE,
        PFX_EXT,
        PFX_BRK,
        PFX_EXTBRK
    } prefix_state_t;

    // Set-2 scan codes
    localparam logic [7:0] SC_E0    = 8'hE0;
    localparam logic [7:0] SC_F0    = 8'hF0;
    localparam logic [7:0] SC_E1    = 8'hE1;
    localparam logic [7:0] SC_A     = 8'h1C;
    localparam logic [7:0] SC_D     = 8'h23;
    localparam logic [7:0] SC_W     = 8'h1D;
    localparam logic [7:0] SC_S     = 8'h1B;
    localparam logic [7:0] SC_SPACE = 8'h29;
    localparam logic [7:0] SC_ENTER = 8'h5A;
    localparam logic [7:0] SC_ESC   = 8'h76;
    localparam logic [7:0] SC_LEFT  = 8'h6B;  // E0-prefixed
    localparam logic [7:0] SC_RIGHT = 8'h74;  // E0-prefixed

    // HID usages
    localparam logic [7:0] KEY_NONE  = 8'h00;
    localparam logic [7:0] KEY_A     = 8'h04;
    localparam logic [7:0] KEY_D     = 8'h07;
    localparam logic [7:0] KEY_W     = 8'h1A;
    localparam logic [7:0] KEY_S     = 8'h16;
    localparam logic [7:0] KEY_SPACE = 8'h2C;
    localparam logic [7:0] KEY_ENTER = 8'h28;
    localparam logic [7:0] KEY_ESC   = 8'h29;
    localparam logic [7:0] KEY_LEFT  = 8'h50;
    localparam logic [7:0] KEY_RIGHT = 8'h4F;

    // Unmapped codes return KEY_NONE, which the key slot logic ignores.
    function automatic logic [7:0] set2_to_hid(input logic ext, input logic [7:0] code);
        logic [7:0] hid;
        hid = KEY_NONE;
        if (!ext) begin
            case (code)
                SC_A:     hid = KEY_A;
                SC_D:     hid = KEY_D;
                SC_W:     hid = KEY_W;
                SC_S:     hid = KEY_S;
                SC_SPACE: hid = KEY_SPACE;
                SC_ENTER: hid = KEY_ENTER;
                SC_ESC:   hid = KEY_ESC;
                default:  hid = KEY_NONE;
            endcase
        end else begin
            case (code)
                SC_LEFT:  hid = KEY_LEFT;
                SC_RIGHT: hid = KEY_RIGHT;
                default:  hid = KEY_NONE;
            endcase
        end
        return hid;
    endfunction

endpackage

// File: rtl/ps2_keycode_if.sv
// Output bundle of the keyboard front end as seen by game logic.
interface ps2_keycode_if;
    logic [7:0] key;
    logic       key_valid;
    logic [7:0] scan_code;
    logic       scan_strobe;
    logic       frame_err;

    modport master (output key, key_valid, scan_code, scan_strobe, frame_err);
    modport slave  (input  key, key_valid, scan_code, scan_strobe, frame_err);
endinterface

// File: rtl/ps2_rx.sv
// PS/2 byte receiver: 2-FF synchronisers, ps2_clk glitch filter, 11-bit frame FSM
// and inter-fall timeout. byte_o/strobe_o/err_o are registered (1 Clk after the fall).
module ps2_rx
    import ps2_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int FILTER_LEN     = 4
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic [7:0] byte_o,
    output logic       strobe_o,
    output logic       err_o
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [1:0]            clk_sync_q, dat_sync_q;
    logic [FILTER_LEN-1:0] filt_hist_q;
    logic                  filt_q, filt_d;
    logic                  fall, data_bit;

    rx_state_t  state_q, state_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shift_q, shift_d;
    logic       par_ok_q, par_ok_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [7:0] byte_q, byte_d;
    logic       strobe_q, strobe_d;
    logic       err_q, err_d;

    // Filtered level only moves after FILTER_LEN identical synced samples.
    always_comb begin
        filt_d = filt_q;
        if (&filt_hist_q)       filt_d = 1'b1;
        else if (~|filt_hist_q) filt_d = 1'b0;
    end

    assign fall     = filt_q & ~filt_d;
    assign data_bit = dat_sync_q[1];

    // Synchronisers and glitch-filter history.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            clk_sync_q  <= '0;
            dat_sync_q  <= '0;
            filt_hist_q <= '0;
            filt_q      <= 1'b0;
        end else begin
            clk_sync_q  <= {clk_sync_q[0], ps2_clk_i};
            dat_sync_q  <= {dat_sync_q[0], ps2_data_i};
            filt_hist_q <= {filt_hist_q[FILTER_LEN-2:0], clk_sync_q[1]};
            filt_q      <= filt_d;
        end
    end

    // Frame FSM state and datapath registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= RX_IDLE;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            par_ok_q  <= 1'b0;
            tmo_q     <= '0;
            byte_q    <= '0;
            strobe_q  <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            par_ok_q  <= par_ok_d;
            tmo_q     <= tmo_d;
            byte_q    <= byte_d;
            strobe_q  <= strobe_d;
            err_q     <= err_d;
        end
    end

    // Next-state: bits are taken on filtered falls; timeout aborts an unfinished frame.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        par_ok_d  = par_ok_q;
        byte_d    = byte_q;
        strobe_d  = 1'b0;
        err_d     = 1'b0;
        tmo_d     = fall ? '0 : tmo_q + TW'(1);

        case (state_q)
            RX_IDLE: begin
                tmo_d = '0;
                if (fall && !data_bit) begin
                    state_d   = RX_DATA;
                    bit_cnt_d = '0;
                end
            end
            RX_DATA: begin
                if (fall) begin
                    shift_d   = {data_bit, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) state_d = RX_PARITY;
                end
            end
            RX_PARITY: begin
                if (fall) begin
                    par_ok_d = ^{shift_q, data_bit};
                    state_d  = RX_STOP;
                end
            end
            RX_STOP: begin
                if (fall) begin
                    if (data_bit && par_ok_q) begin
                        byte_d   = shift_q;
                        strobe_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                    state_d = RX_IDLE;
                end
            end
            default: state_d = RX_IDLE;
        endcase

        if (state_q != RX_IDLE && !fall && tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
            state_d = RX_IDLE;
            err_d   = 1'b1;
            tmo_d   = '0;
        end
    end

    assign byte_o   = byte_q;
    assign strobe_o = strobe_q;
    assign err_o    = err_q;

endmodule

// File: rtl/ps2_keycode.sv
// PS/2 set-2 keyboard to HID keycode front end: prefix tracking, translation, key slot.
// Build option KEY_ROLLOVER_EN adds a prev_key slot restored when the newest key is released.
module ps2_keycode
    import ps2_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int FILTER_LEN     = 4
) (
    input  logic          Clk,
    input  logic          Reset_n,
    input  logic          ps2_clk_i,
    input  logic          ps2_data_i,
    ps2_keycode_if.master kbd
);

    logic [7:0] rx_byte;
    logic       rx_strobe, rx_err;

    ps2_rx #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .FILTER_LEN     (FILTER_LEN)
    ) u_rx (
        .clk_i      (Clk),
        .rst_ni     (Reset_n),
        .ps2_clk_i  (ps2_clk_i),
        .ps2_data_i (ps2_data_i),
        .byte_o     (rx_byte),
        .strobe_o   (rx_strobe),
        .err_o      (rx_err)
    );

    prefix_state_t pfx_q, pfx_d;
    logic          code_vld, code_ext, code_brk;
    logic [7:0]    hid;
    logic [7:0]    key_q, key_d;
    logic          kv_q, kv_d;
`ifdef KEY_ROLLOVER_EN
    logic [7:0]    prev_q, prev_d;
`endif

    // Prefix state register.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) pfx_q <= PFX_NONE;
        else          pfx_q <= pfx_d;
    end

    // Prefix next-state; flags a completed code (make/break, extended) on its strobe.
    always_comb begin
        pfx_d    = pfx_q;
        code_vld = 1'b0;
        code_ext = 1'b0;
        code_brk = 1'b0;
        if (rx_err) begin
            pfx_d = PFX_NONE;
        end else if (rx_strobe) begin
            case (pfx_q)
                PFX_NONE: begin
                    if (rx_byte == SC_E0)      pfx_d = PFX_EXT;
                    else if (rx_byte == SC_F0) pfx_d = PFX_BRK;
                    else if (rx_byte != SC_E1) code_vld = 1'b1;
                end
                PFX_EXT: begin
                    if (rx_byte == SC_F0) pfx_d = PFX_EXTBRK;
                    else begin
                        pfx_d = PFX_NONE;
                        if (rx_byte != SC_E0 && rx_byte != SC_E1) begin
                            code_vld = 1'b1;
                            code_ext = 1'b1;
                        end
                    end
                end
                default: begin  // PFX_BRK, PFX_EXTBRK
                    pfx_d = PFX_NONE;
                    if (rx_byte != SC_E0 && rx_byte != SC_F0 && rx_byte != SC_E1) begin
                        code_vld = 1'b1;
                        code_brk = 1'b1;
                        code_ext = (pfx_q == PFX_EXTBRK);
                    end
                end
            endcase
        end
    end

    assign hid = set2_to_hid(code_ext, rx_byte);

    // Key slot registers.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            key_q  <= KEY_NONE;
            kv_q   <= 1'b0;
`ifdef KEY_ROLLOVER_EN
            prev_q <= KEY_NONE;
`endif
        end else begin
            key_q  <= key_d;
            kv_q   <= kv_d;
`ifdef KEY_ROLLOVER_EN
            prev_q <= prev_d;
`endif
        end
    end

    // Key update: mapped makes replace the key, a break of the key clears (or restores) it.
    always_comb begin
        key_d  = key_q;
        kv_d   = 1'b0;
`ifdef KEY_ROLLOVER_EN
        prev_d = prev_q;
`endif
        if (code_vld && hid != KEY_NONE) begin
            if (!code_brk) begin
                if (hid != key_q) begin
`ifdef KEY_ROLLOVER_EN
                    prev_d = key_q;
`endif
                    key_d = hid;
                    kv_d  = 1'b1;
                end
            end else if (hid == key_q) begin
`ifdef KEY_ROLLOVER_EN
                key_d  = prev_q;
                prev_d = KEY_NONE;
`else
                key_d  = KEY_NONE;
`endif
                kv_d = 1'b1;
            end
`ifdef KEY_ROLLOVER_EN
            else if (hid == prev_q) begin
                prev_d = KEY_NONE;
            end
`endif
        end
    end

    assign kbd.key         = key_q;
    assign kbd.key_valid   = kv_q;
    assign kbd.scan_code   = rx_byte;
    assign kbd.scan_strobe = rx_strobe;
    assign kbd.frame_err   = rx_err;

endmodule

// File: tb/tb_ps2_keycode.sv
// Directed bench for ps2_keycode: drives PS/2 frames, tracks expected bytes and key
// changes with a keyboard-level model, and checks every cycle from one monitor process.
module tb_ps2_keycode;

    localparam int TMO  = 300;
    localparam int FL   = 4;
    localparam int HALF = 10;   // Clk cycles per PS/2 clock half period

    logic Clk = 1'b0;
    logic Reset_n = 1'b0;
    logic ps2_clk = 1'b1;
    logic ps2_data = 1'b1;

    ps2_keycode_if kif ();

    ps2_keycode #(.TIMEOUT_CYCLES(TMO), .FILTER_LEN(FL)) dut (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .ps2_clk_i  (ps2_clk),
        .ps2_data_i (ps2_data),
        .kbd        (kif)
    );

    always #5 Clk = ~Clk;

    int n_cmp = 0, n_bad = 0;
    int n_strobe = 0, n_valid = 0, n_err = 0;
    int s_strobe, s_valid, s_err;

    // Model: what a keyboard user would see
    logic [7:0] exp_b[$];
    logic [7:0] exp_k[$];
    bit         m_ext = 0, m_brk = 0;
    logic [7:0] m_key = 8'h00, m_prev = 8'h00;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] usage(input bit ext, input logic [7:0] code);
        case ({ext, code})
            9'h01C: return 8'h04;
            9'h023: return 8'h07;
            9'h01D: return 8'h1A;
            9'h01B: return 8'h16;
            9'h029: return 8'h2C;
            9'h05A: return 8'h28;
            9'h076: return 8'h29;
            9'h16B: return 8'h50;
            9'h174: return 8'h4F;
            default: return 8'h00;
        endcase
    endfunction

    task automatic model_byte(input logic [7:0] b);
        logic [7:0] h;
        exp_b.push_back(b);
        if (b == 8'hE0 && !m_ext && !m_brk) m_ext = 1;
        else if (b == 8'hF0 && !m_brk)      m_brk = 1;
        else if (b == 8'hE0 || b == 8'hF0 || b == 8'hE1) begin m_ext = 0; m_brk = 0; end
        else begin
            h = usage(m_ext, b);
            if (h != 8'h00) begin
                if (!m_brk) begin
                    if (h != m_key) begin
`ifdef KEY_ROLLOVER_EN
                        m_prev = m_key;
`endif
                        m_key = h;
                        exp_k.push_back(h);
                    end
                end else if (h == m_key) begin
`ifdef KEY_ROLLOVER_EN
                    m_key = m_prev;
`else
                    m_key = 8'h00;
`endif
                    m_prev = 8'h00;
                    exp_k.push_back(m_key);
                end else if (h == m_prev) m_prev = 8'h00;
            end
            m_ext = 0; m_brk = 0;
        end
    endtask

    // Frame bits: start 0, data LSB first, odd parity (optionally flipped), stop 1.
    task automatic send_bits(input logic [7:0] b, input bit flip_par, input int nbits);
        logic [10:0] fr;
        fr = {1'b1, (~^b) ^ flip_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2_data = fr[i];
            repeat (HALF) @(posedge Clk);
            ps2_clk = 1'b0;
            repeat (HALF) @(posedge Clk);
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
    endtask

    task automatic send(input logic [7:0] b);
        model_byte(b);
        send_bits(b, 1'b0, 11);
        repeat (30) @(posedge Clk);
    endtask

    task automatic snap();
        s_strobe = n_strobe; s_valid = n_valid; s_err = n_err;
    endtask

    task automatic deltas(input string name, input int ds, input int dv, input int de);
        chk({name, " strobes"}, 32'(n_strobe - s_strobe), 32'(ds));
        chk({name, " key_valids"}, 32'(n_valid - s_valid), 32'(dv));
        chk({name, " frame_errs"}, 32'(n_err - s_err), 32'(de));
    endtask

    // Monitor: per-cycle check of bytes, key changes and their latency.
    logic [7:0] prev_key = 8'h00;
    logic       prev_strobe = 1'b0;
    always @(negedge Clk) begin
        if (!Reset_n) begin
            prev_key = kif.key;
            prev_strobe = 1'b0;
        end else begin
            if (kif.scan_strobe) begin
                n_strobe++;
                if (exp_b.size() == 0) chk("unexpected scan_strobe", 32'(kif.scan_code), 32'hFFFF_FFFF);
                else chk("scan_code", 32'(kif.scan_code), 32'(exp_b.pop_front()));
            end
            if (kif.key_valid) begin
                n_valid++;
                chk("key_valid follows strobe", 32'(prev_strobe), 32'd1);
                if (exp_k.size() == 0) chk("unexpected key_valid", 32'(kif.key), 32'hFFFF_FFFF);
                else chk("key on key_valid", 32'(kif.key), 32'(exp_k.pop_front()));
            end else begin
                chk("key stable w/o key_valid", 32'(kif.key), 32'(prev_key));
            end
            if (kif.frame_err) n_err++;
            prev_key = kif.key;
            prev_strobe = kif.scan_strobe;
        end
    end

    initial begin
        repeat (5) @(posedge Clk);
        #1;
        chk("reset key", 32'(kif.key), 32'h00);
        chk("reset scan_code", 32'(kif.scan_code), 32'h00);
        chk("reset pulses", 32'({kif.key_valid, kif.scan_strobe, kif.frame_err}), 32'd0);
        Reset_n = 1'b1;
        repeat (20) @(posedge Clk);

        // Single make
        snap(); send(8'h1C);
        deltas("make A", 1, 1, 0);
        chk("make A key", 32'(kif.key), 32'h04);
        chk("make A scan_code", 32'(kif.scan_code), 32'h1C);

        // Typematic repeats then release
        snap(); send(8'h1C); send(8'h1C); send(8'h1C);
        deltas("typematic", 3, 0, 0);
        chk("typematic key", 32'(kif.key), 32'h04);
        snap(); send(8'hF0); send(8'h1C);
        deltas("break A", 2, 1, 0);
        chk("break A key", 32'(kif.key), 32'h00);

        // Extended make/break, bare 74 is unmapped
        snap(); send(8'hE0); send(8'h74);
        chk("E0 74 key", 32'(kif.key), 32'h4F);
        send(8'hE0); send(8'hF0); send(8'h74);
        deltas("ext right", 5, 2, 0);
        chk("E0 F0 74 key", 32'(kif.key), 32'h00);
        send(8'h1C);
        snap(); send(8'h74);
        deltas("bare 74", 1, 0, 0);
        chk("bare 74 key", 32'(kif.key), 32'h04);

        // Parity error, then normal decoding resumes
        snap();
        m_ext = 0; m_brk = 0;
        send_bits(8'h23, 1'b1, 11);
        repeat (30) @(posedge Clk);
        deltas("bad parity", 0, 0, 1);
        chk("bad parity key", 32'(kif.key), 32'h04);
        snap(); send(8'hF0); send(8'h1C);
        deltas("after error", 2, 1, 0);
        chk("after error key", 32'(kif.key), 32'h00);

        // Truncated frame -> timeout
        snap();
        m_ext = 0; m_brk = 0;
        send_bits(8'h23, 1'b0, 5);
        repeat (TMO + 60) @(posedge Clk);
        deltas("timeout", 0, 0, 1);
        snap(); send(8'h23);
        deltas("after timeout", 1, 1, 0);
        chk("after timeout key", 32'(kif.key), 32'h07);

        // Two keys held, release the newer
        send(8'hF0); send(8'h23);
        send(8'h1C);
        chk("rollover step1", 32'(kif.key), 32'h04);
        send(8'h23);
        chk("rollover step2", 32'(kif.key), 32'h07);
        send(8'hF0); send(8'h23);
`ifdef KEY_ROLLOVER_EN
        chk("rollover step3", 32'(kif.key), 32'h04);
`else
        chk("rollover step3", 32'(kif.key), 32'h00);
`endif
        chk("model agrees", 32'(kif.key), 32'(m_key));

        // Reset mid-frame
        send(8'h1D);
        send_bits(8'h1C, 1'b0, 6);
        @(posedge Clk); #1;
        Reset_n = 1'b0;
        repeat (3) @(posedge Clk);
        #1;
        chk("mid-frame reset key", 32'(kif.key), 32'h00);
        chk("mid-frame reset pulses", 32'({kif.key_valid, kif.scan_strobe, kif.frame_err}), 32'd0);
        m_key = 8'h00; m_prev = 8'h00; m_ext = 0; m_brk = 0;
        exp_b.delete(); exp_k.delete();
        Reset_n = 1'b1;
        repeat (20) @(posedge Clk);
        snap(); send(8'h1D);
        deltas("after reset", 1, 1, 0);
        chk("after reset key", 32'(kif.key), 32'h1A);

        chk("pending bytes", 32'(exp_b.size()), 32'd0);
        chk("pending keys", 32'(exp_k.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
